// File: rtl/jtdd2_pkg.sv
// Shared constants for the sub-CPU controller: halt FSM encoding,
// control register bit positions and a counter-width helper.
package jtdd2_pkg;

  // Halt handshake states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_REL    = 2'd3;

  // Control register bit positions
  localparam int CTL_RUN  = 0;
  localparam int CTL_HALT = 1;
  localparam int CTL_NMI  = 2;

  // Bits needed to hold the value n (at least one bit)
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jtdd2_subctl_pulse.sv
// Retriggerable fixed-width pulse generator: o_pulse is high for exactly
// W clocks after the most recent i_trig.
module jtdd2_subctl_pulse
  import jtdd2_pkg::*;
#(
  parameter int W = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_trig,
  output logic o_pulse
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LOAD = CW'(W);

  logic [CW-1:0] r_cnt;

  // Down-counter: a trigger (re)loads the full width, otherwise run to zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_trig) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/jtdd2_subctl.sv
// Main-to-sub CPU controller: sub reset sequencing, NMI trigger, bus
// halt handshake with timeout, and sub-to-main IRQ latch.
//
// state  | meaning
// RUN    | sub owns its bus, no halt requested
// REQ    | halt requested, waiting for mcu_ban or timeout
// HALTED | sub bus released, main may access shared RAM
// REL    | halt withdrawn, waiting for sub to resume (mcu_ban high)
module jtdd2_subctl
  import jtdd2_pkg::*;
#(
  parameter int RST_HOLD = 8,
  parameter int NMI_W    = 16,
  parameter int HALT_TO  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       main_wrn,
  input  logic [7:0] main_dout,
  input  logic       ctl_cs,
  input  logic       ack_cs,
  input  logic       mcu_ban,
  input  logic       mcu_irqmain,
  output logic       mcu_rstb,
  output logic       mcu_halt,
  output logic       mcu_nmi_set,
  output logic       shared_ok,
  output logic       main_irqn,
  output logic [7:0] status
);

  localparam int HW = cnt_w(RST_HOLD);
  localparam int TW = cnt_w(HALT_TO);
  localparam logic [HW-1:0] HOLD_LD = HW'(RST_HOLD);
  localparam logic [TW-1:0] TO_LD   = TW'((HALT_TO > 0) ? HALT_TO - 1 : 0);

  logic [2:0]    r_ctl;
  logic [HW-1:0] r_hold_cnt;
  logic          r_rstb;
  logic [1:0]    r_st;
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  logic          r_irq_d;
  logic          r_irq_pend;
  logic          r_irqn;
  logic [7:0]    r_status;

  logic          w_wr;
  logic          w_ack;
  logic          w_run;
  logic          w_halt_req;
  logic          w_nmi_trig;
  logic          w_halt_rise;
  logic          w_irq_rise;
  logic          w_irq_nxt;
  logic          w_shared_ok;
  logic [1:0]    w_st_nxt;
  logic          w_to_ld;
  logic          w_to_dec;
  logic          w_to_set;
  logic          w_unused;

  assign w_wr       = cpu_cen & ~main_wrn & ctl_cs;
  assign w_ack      = cpu_cen & ~main_wrn & ack_cs;
  assign w_run      = r_ctl[CTL_RUN];
  assign w_halt_req = r_ctl[CTL_HALT];
  assign w_unused   = ^main_dout[7:3];

  // Edges of the control bits are taken between consecutive writes
  assign w_nmi_trig  = w_wr & main_dout[CTL_NMI] & ~r_ctl[CTL_NMI] & r_rstb;
  assign w_halt_rise = w_wr & main_dout[CTL_HALT] & ~r_ctl[CTL_HALT];

  // Control register write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl <= 3'b000;
    end else if (w_wr) begin
      r_ctl <= main_dout[2:0];
    end
  end

  // Sub reset hold: counts cpu_cen pulses once run is requested, reloads while stopped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= HOLD_LD;
      r_rstb     <= 1'b0;
    end else begin
      if (!w_run) begin
        r_hold_cnt <= HOLD_LD;
      end else if (cpu_cen && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      r_rstb <= w_run && (r_hold_cnt == '0);
    end
  end

  jtdd2_subctl_pulse #(
    .W(NMI_W)
  ) u_nmi (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_trig (w_nmi_trig),
    .o_pulse(mcu_nmi_set)
  );

  // Halt FSM next-state and timer control; a sub held in reset cannot own the bus
  always_comb begin
    w_st_nxt = r_st;
    w_to_ld  = 1'b0;
    w_to_dec = 1'b0;
    w_to_set = 1'b0;
    case (r_st)
      ST_RUN: begin
        if (w_halt_req) begin
          w_st_nxt = ST_REQ;
          w_to_ld  = 1'b1;
        end
      end
      ST_REQ: begin
        if (!w_halt_req) begin
          w_st_nxt = ST_REL;
          w_to_ld  = 1'b1;
        end else if (!mcu_ban) begin
          w_st_nxt = ST_HALTED;
        end else if (r_to_cnt == '0) begin
          w_st_nxt = ST_HALTED;
          w_to_set = 1'b1;
        end else begin
          w_to_dec = 1'b1;
        end
      end
      ST_HALTED: begin
        if (!w_halt_req) begin
          w_st_nxt = ST_REL;
          w_to_ld  = 1'b1;
        end
      end
      ST_REL: begin
        if (mcu_ban || (r_to_cnt == '0)) begin
          w_st_nxt = ST_RUN;
        end else begin
          w_to_dec = 1'b1;
        end
      end
      default: w_st_nxt = ST_RUN;
    endcase
    if (!r_rstb) begin
      w_st_nxt = ST_RUN;
      w_to_ld  = 1'b0;
      w_to_dec = 1'b0;
      w_to_set = 1'b0;
    end
  end

  // Halt FSM state and handshake timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= ST_RUN;
      r_to_cnt <= TO_LD;
    end else begin
      r_st <= w_st_nxt;
      if (w_to_ld) begin
        r_to_cnt <= TO_LD;
      end else if (w_to_dec) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
    end
  end

  // Sticky timeout flag, cleared by a fresh halt request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_to_set) begin
      r_timeout <= 1'b1;
    end else if (w_halt_rise) begin
      r_timeout <= 1'b0;
    end
  end

  assign mcu_halt    = r_rstb & ((r_st == ST_REQ) | (r_st == ST_HALTED));
  assign w_shared_ok = ~r_rstb | (r_st == ST_HALTED);
  assign shared_ok   = w_shared_ok;

  // IRQ edge detect runs every clock; a new edge beats a simultaneous ack
  assign w_irq_rise = mcu_irqmain & ~r_irq_d;
  assign w_irq_nxt  = w_irq_rise ? 1'b1 : (w_ack ? 1'b0 : r_irq_pend);

  // IRQ latch and registered active-low output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_d    <= 1'b0;
      r_irq_pend <= 1'b0;
      r_irqn     <= 1'b1;
    end else begin
      r_irq_d    <= mcu_irqmain;
      r_irq_pend <= w_irq_nxt;
      r_irqn     <= ~w_irq_nxt;
    end
  end

  // Status readback, one clock behind the flags it reports
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= 8'h02;
    end else begin
      r_status <= {4'b0000, r_timeout, r_irq_pend, w_shared_ok, r_rstb};
    end
  end

  assign mcu_rstb  = r_rstb;
  assign main_irqn = r_irqn;
  assign status    = r_status;

endmodule

// File: tb/tb_jtdd2_subctl.sv
// Directed bench for jtdd2_subctl: stimulus queues expected values,
// negedge monitors compare point checks and measure NMI pulse widths.
module tb_jtdd2_subctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_cen = 1'b0;
  logic       main_wrn = 1'b1;
  logic [7:0] main_dout = 8'h00;
  logic       ctl_cs = 1'b0;
  logic       ack_cs = 1'b0;
  logic       mcu_ban = 1'b1;
  logic       mcu_irqmain = 1'b0;
  logic       mcu_rstb, mcu_halt, mcu_nmi_set, shared_ok, main_irqn;
  logic [7:0] status;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int S_RSTB = 0, S_HALT = 1, S_NMI = 2, S_SHR = 3, S_IRQN = 4, S_STAT = 5;

  typedef struct {
    string      name;
    int         id;
    logic [7:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   nmi_q[$];
  int   run_len = 0;

  always #5 clk = ~clk;

  jtdd2_subctl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_cen    (cpu_cen),
    .main_wrn   (main_wrn),
    .main_dout  (main_dout),
    .ctl_cs     (ctl_cs),
    .ack_cs     (ack_cs),
    .mcu_ban    (mcu_ban),
    .mcu_irqmain(mcu_irqmain),
    .mcu_rstb   (mcu_rstb),
    .mcu_halt   (mcu_halt),
    .mcu_nmi_set(mcu_nmi_set),
    .shared_ok  (shared_ok),
    .main_irqn  (main_irqn),
    .status     (status)
  );

  function automatic logic [7:0] probe(input int id);
    case (id)
      S_RSTB:  return {7'd0, mcu_rstb};
      S_HALT:  return {7'd0, mcu_halt};
      S_NMI:   return {7'd0, mcu_nmi_set};
      S_SHR:   return {7'd0, shared_ok};
      S_IRQN:  return {7'd0, main_irqn};
      default: return status;
    endcase
  endfunction

  // Point-check monitor
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t       c;
      logic [7:0] act;
      c   = chk_q.pop_front();
      act = probe(c.id);
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %02h, want %02h", c.name, act, c.exp);
      end
    end
  end

  // NMI pulse-width monitor
  always @(negedge clk) begin
    if (mcu_nmi_set === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      n_cmp++;
      if (nmi_q.size() == 0) begin
        n_bad++;
        $display("FAIL nmi_unexpected: pulse of %0d clk, want none", run_len);
      end else begin
        int w;
        w = nmi_q.pop_front();
        if (w != run_len) begin
          n_bad++;
          $display("FAIL nmi_width: got %0d clk, want %0d clk", run_len, w);
        end
      end
      run_len = 0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_chk(input string nm, input int id, input logic [7:0] v);
    chk_t c;
    c.name = nm;
    c.id   = id;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic wr_ctl(input logic [7:0] d);
    cpu_cen   = 1'b1;
    main_wrn  = 1'b0;
    ctl_cs    = 1'b1;
    main_dout = d;
    step();
    cpu_cen  = 1'b0;
    main_wrn = 1'b1;
    ctl_cs   = 1'b0;
  endtask

  task automatic cen_pulses(input int n);
    repeat (n) begin
      cpu_cen = 1'b1;
      step();
      cpu_cen = 1'b0;
      step();
    end
  endtask

  task automatic ack_wr(input logic cen);
    cpu_cen  = cen;
    main_wrn = 1'b0;
    ack_cs   = 1'b1;
    step();
    cpu_cen  = 1'b0;
    main_wrn = 1'b1;
    ack_cs   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    exp_chk({tag, "_rstb"}, S_RSTB, 8'h00);
    exp_chk({tag, "_halt"}, S_HALT, 8'h00);
    exp_chk({tag, "_nmi"},  S_NMI,  8'h00);
    exp_chk({tag, "_shr"},  S_SHR,  8'h01);
    exp_chk({tag, "_irqn"}, S_IRQN, 8'h01);
    exp_chk({tag, "_stat"}, S_STAT, 8'h02);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want normal end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check_reset("por");
    rst = 1'b0;
    step();

    // Reset release with a mid-count restart
    wr_ctl(8'h01);
    cen_pulses(3);
    exp_chk("hold_cnt3", S_RSTB, 8'h00);
    wr_ctl(8'h00);
    wr_ctl(8'h01);
    cen_pulses(7);
    exp_chk("restart_7", S_RSTB, 8'h00);
    cpu_cen = 1'b1;
    step();
    exp_chk("rel_edge", S_RSTB, 8'h00);
    cpu_cen = 1'b0;
    step();
    exp_chk("rel_plus1", S_RSTB, 8'h01);
    exp_chk("shared_run", S_SHR, 8'h00);
    step();
    exp_chk("status_run", S_STAT, 8'h01);

    // NMI pulse, repeated write without a 0, retrigger
    nmi_q.push_back(16);
    wr_ctl(8'h05);
    step(20);
    wr_ctl(8'h05);
    step(20);
    wr_ctl(8'h01);
    nmi_q.push_back(22);
    wr_ctl(8'h05);
    step(4);
    wr_ctl(8'h01);
    wr_ctl(8'h05);
    step(25);

    // Halt handshake
    wr_ctl(8'h03);
    step();
    exp_chk("halt_req", S_HALT, 8'h01);
    exp_chk("shared_in_req", S_SHR, 8'h00);
    step(4);
    mcu_ban = 1'b0;
    step();
    exp_chk("shared_halted", S_SHR, 8'h01);
    exp_chk("halt_halted", S_HALT, 8'h01);
    step();
    exp_chk("status_halted", S_STAT, 8'h03);
    wr_ctl(8'h01);
    mcu_ban = 1'b1;
    step();
    exp_chk("halt_rel", S_HALT, 8'h00);
    step();
    exp_chk("halt_run", S_HALT, 8'h00);
    exp_chk("shared_run2", S_SHR, 8'h00);

    // Halt timeout with mcu_ban held high
    wr_ctl(8'h03);
    step(1024);
    exp_chk("to_pre_shr", S_SHR, 8'h00);
    exp_chk("to_pre_halt", S_HALT, 8'h01);
    step();
    exp_chk("to_shared", S_SHR, 8'h01);
    step();
    exp_chk("to_status", S_STAT, 8'h0B);
    wr_ctl(8'h01);
    step(2);
    exp_chk("to_sticky", S_STAT, 8'h09);
    wr_ctl(8'h03);
    step();
    exp_chk("to_clear", S_STAT, 8'h01);
    wr_ctl(8'h01);
    step(2);

    // IRQ latch, collision and acknowledge
    mcu_irqmain = 1'b1;
    step();
    exp_chk("irq_set", S_IRQN, 8'h00);
    step();
    exp_chk("status_irq", S_STAT, 8'h05);
    mcu_irqmain = 1'b0;
    step();
    mcu_irqmain = 1'b1;
    ack_wr(1'b1);
    exp_chk("irq_collide", S_IRQN, 8'h00);
    step();
    exp_chk("irq_hold", S_IRQN, 8'h00);
    ack_wr(1'b1);
    exp_chk("irq_ack", S_IRQN, 8'h01);
    mcu_irqmain = 1'b0;
    step();
    mcu_irqmain = 1'b1;
    step();
    mcu_irqmain = 1'b0;
    ack_wr(1'b0);
    exp_chk("ack_no_cen", S_IRQN, 8'h00);
    ack_wr(1'b1);
    exp_chk("irq_ack2", S_IRQN, 8'h01);

    // Reset in the middle of an NMI pulse
    nmi_q.push_back(4);
    wr_ctl(8'h05);
    step(3);
    rst = 1'b1;
    step();
    check_reset("rst_nmi");
    rst = 1'b0;
    step();

    // NMI request while the sub is held in reset
    wr_ctl(8'h04);
    step();
    exp_chk("nmi_in_reset", S_NMI, 8'h00);
    step(20);

    // Reset while a halt request is pending
    wr_ctl(8'h01);
    cen_pulses(8);
    exp_chk("rel2", S_RSTB, 8'h01);
    wr_ctl(8'h03);
    step();
    exp_chk("req2", S_HALT, 8'h01);
    mcu_irqmain = 1'b1;
    step(3);
    exp_chk("irq_pre_rst", S_IRQN, 8'h00);
    step();
    rst = 1'b1;
    mcu_irqmain = 1'b0;
    step();
    check_reset("rst_req");
    rst = 1'b0;
    step(3);

    n_cmp++;
    if (nmi_q.size() != 0) begin
      n_bad++;
      $display("FAIL nmi_missing: %0d expected pulses not seen, want 0", nmi_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtdd2_subctl.md
JTDD2_SUBCTL -- requirements
Module: jtdd2_subctl

Interface
REQ-001 Parameter RST_HOLD, default 8: minimum sub-reset assertion, in cpu_cen pulses.
REQ-002 Parameter NMI_W, default 16: mcu_nmi_set pulse width, in clk cycles.
REQ-003 Parameter HALT_TO, default 1024: halt-grant timeout, in clk cycles.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port cpu_cen, input, 1: main CPU clock enable; bus writes are sampled only when it is high.
REQ-007 Port main_wrn, input, 1: main CPU write strobe, active low.
REQ-008 Port main_dout, input, 8: main CPU write data.
REQ-009 Port ctl_cs, input, 1: decoded select for the sub-control register.
REQ-010 Port ack_cs, input, 1: decoded select for the sub-IRQ acknowledge.
REQ-011 Port mcu_ban, input, 1: sub bus acknowledge, active low.
REQ-012 Port mcu_irqmain, input, 1: sub-to-main interrupt request, level.
REQ-013 Port mcu_rstb, output, 1: sub reset, active low.
REQ-014 Port mcu_halt, output, 1: sub bus-request (halt).
REQ-015 Port mcu_nmi_set, output, 1: sub NMI trigger pulse.
REQ-016 Port shared_ok, output, 1: main CPU may write shared RAM.
REQ-017 Port main_irqn, output, 1: IRQ to main CPU, active low.
REQ-018 Port status, output, 8: readback {4'b0, timeout, irq_pend, shared_ok, mcu_rstb}.

Function
REQ-019 Write event: a write occurs when cpu_cen && !main_wrn && ctl_cs; the register is ctl[2:0] <= main_dout[2:0].
REQ-020 Write event bit meaning: bit0 run_req, bit1 halt_req, bit2 nmi_req.
REQ-021 Reset hold: while run_req=0, mcu_rstb=0 and a hold counter loads RST_HOLD.
REQ-022 Reset release: after run_req=1, the counter decrements once per cpu_cen, and mcu_rstb rises in the clk cycle after the counter reaches 0.
REQ-023 Reset re-entry: clearing run_req while counting reloads the counter.
REQ-024 NMI trigger: a 0->1 transition of ctl[2] between consecutive writes starts a pulse; mcu_nmi_set=1 for exactly NMI_W clk cycles.
REQ-025 NMI re-trigger: a new 0->1 transition during an active pulse restarts the count to NMI_W.
REQ-026 NMI while in reset: NMI triggers are ignored while mcu_rstb=0.
REQ-027 Halt FSM states: RUN, REQ, HALTED, REL; mcu_halt=1 in REQ and HALTED.
REQ-028 RUN: goes to REQ when halt_req=1.
REQ-029 REQ: goes to HALTED when mcu_ban=0.
REQ-030 REQ timeout: if HALT_TO cycles elapse in REQ, the FSM goes to HALTED and sets sticky timeout.
REQ-031 REQ withdrawal: if halt_req=0 while in REQ, the FSM goes to REL.
REQ-032 HALTED: shared_ok=1; goes to REL when halt_req=0.
REQ-033 REL: mcu_halt=0; goes to RUN when mcu_ban=1, or after HALT_TO cycles.
REQ-034 Sub in reset: while mcu_rstb=0, the FSM is forced to RUN and shared_ok=1, since the sub is not bus master.
REQ-035 Timeout clear: timeout clears on the next 0->1 of halt_req.
REQ-036 IRQ latch: a rising edge of mcu_irqmain sets irq_pend.
REQ-037 IRQ acknowledge: a write with ack_cs (cpu_cen && !main_wrn) clears irq_pend.
REQ-038 IRQ collision: if set and clear occur in the same cycle, set wins.
REQ-039 IRQ output: main_irqn = ~irq_pend, registered.
REQ-040 IRQ edge detector: the mcu_irqmain edge detector operates regardless of cpu_cen.
REQ-041 Status timing: status is registered and reflects state one clk after any change.

Reset
REQ-042 On rst: ctl=3'b000, mcu_rstb=0, hold counter=RST_HOLD, mcu_halt=0, FSM=RUN, mcu_nmi_set=0, irq_pend=0, main_irqn=1, timeout=0, shared_ok=1, status=8'h02.
REQ-043 rst asserted mid-pulse or mid-handshake terminates it in the same cycle with no residual pulse.

Structure
REQ-044 The FSM state encoding and the ctl bit-index constants shall live in a shared package (jtdd2_pkg).
REQ-045 One sub-module, jtdd2_subctl_pulse (retriggerable fixed-width pulse generator), shall be used for the NMI pulse.

Verification
REQ-046 Reset release: write 8'h01 after reset -> mcu_rstb rises after 8 cpu_cen pulses (+1 clk); writing 8'h00 at count 3 reloads, and the count restarts from 8.
REQ-047 NMI: with run=1, write 8'h01 then 8'h05 -> mcu_nmi_set high exactly 16 clk; writing 8'h05 again with no 0 in between -> no pulse.
REQ-048 Halt handshake: write 8'h03, drive mcu_ban=0 after 5 clk -> mcu_halt=1 at once, shared_ok=1 one clk after mcu_ban falls; then write 8'h01 and drive mcu_ban=1 -> FSM RUN, shared_ok=0.
REQ-049 Halt timeout: write 8'h03 with mcu_ban held 1 -> after 1024 clk, shared_ok=1 and status[3]=1; a new 0->1 of halt_req clears status[3].
REQ-050 IRQ: pulse mcu_irqmain -> main_irqn=0 next clk; an ack write in the same cycle as a new irq edge leaves main_irqn=0; an ack alone -> main_irqn=1.
REQ-051 rst during an NMI pulse or in REQ -> all outputs match the reset values in REQ-042 on the next clk.
